alu_serial_ctrl: RTL and testbench
==================================

Name: alu_serial_ctrl

Overview:
- Bit-serial sequencer for the team's 1-bit ALU slice (AND/OR/add/less mux, bitInvert, cin/cout, set).
- Accepts a WIDTH-bit operation request and feeds operands through one external slice, LSB first, one bit per clock.
- Carries cout forward in a register and assembles the WIDTH-bit result.
- SLT uses a second pass that routes the captured MSB set bit into the slice's less input.
- Sits between the datapath register file and a single shared ALU slice instance.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)

Ports:
clk  in  1  clock, rising-edge
rst  in  1  synchronous reset, active-high
start  in  1  request strobe; sampled only in IDLE
op  in  3  0=AND 1=OR 2=ADD 3=SUB 4=SLT 5..7=illegal
src_a  in  WIDTH  operand A, captured on accepted start
src_b  in  WIDTH  operand B, captured on accepted start
busy  out  1  high from the cycle after an accepted start through the last slice cycle
done  out  1  one-cycle pulse; result/zero/illegal valid from this cycle
result  out  WIDTH  final result; held until next accepted start
zero  out  1  result==0, registered with result
illegal  out  1  high with done when op was 5..7
alu_a  out  1  to slice a
alu_b  out  1  to slice b
alu_invert  out  1  to slice bitInvert
alu_cin  out  1  to slice cin
alu_less  out  1  to slice less
alu_operation  out  3  to slice operation select: 000 AND, 001 OR, 010 sum, 011 less
alu_dataOut  in  1  from slice dataOut
alu_set  in  1  from slice set (sum bit)
alu_cout  in  1  from slice cout

Behaviour:
- Reset: state=IDLE; busy, done, illegal, zero, result, all alu_* outputs = 0; bit counter = 0; carry = 0; slt flag = 0.
- Reset mid-operation aborts the operation: no done pulse; result is cleared to 0.
- States: IDLE, RUN, SLTP, DONE.
- IDLE:
  - start=1 with op 0..4: capture src_a/src_b into shift registers; counter=0; carry = 1 for SUB/SLT, else 0; go to RUN.
  - start=1 with op 5..7: go to DONE with result=0, illegal=1.
  - start=0: stay.
- RUN (WIDTH cycles):
  - Drive alu_a/alu_b = LSB of shift registers; alu_cin = carry; alu_invert = 1 for SUB/SLT.
  - alu_operation: 000 AND, 001 OR, 010 ADD/SUB/SLT; alu_less = 0.
  - On each edge: shift alu_dataOut into result MSB (right-shift assembly); carry <= alu_cout; shift operands right; counter++.
  - When counter == WIDTH-1, slt flag <= alu_set (sign of A-B; overflow not corrected, matching ripple ALU semantics).
  - After the WIDTH-th bit: SLT goes to SLTP with counter=0; all other ops go to DONE.
- SLTP (WIDTH cycles):
  - alu_operation = 011; alu_less = slt flag on bit 0, 0 on other bits; alu_a/alu_b/alu_cin = 0.
  - dataOut is shifted into result as in RUN; then go to DONE.
- DONE (1 cycle): done=1; zero = (result==0); busy=0; return to IDLE. start here is ignored.
- start while busy or in DONE is ignored; src_a/src_b changes after capture have no effect.
- Latency (accepted start to done): AND/OR/ADD/SUB = WIDTH+1 cycles; SLT = 2*WIDTH+1; illegal = 1.
- ADD/SUB wrap modulo 2^WIDTH; final carry out is discarded.
- result and zero hold their values until the next accepted start clears them.
- alu_* outputs are 0 in IDLE and DONE.

Test Plan:
- WIDTH=8, ADD a=0xF0 b=0x1F -> done 9 cycles after start, result=0x0F, zero=0; 8 busy cycles.
- WIDTH=8, SUB a=0x05 b=0x05 -> result=0x00, zero=1; alu_invert=1 and alu_cin=1 on the first RUN cycle.
- WIDTH=8, SLT a=0x03 b=0x07 -> done at 17 cycles, result=0x01; SLT a=0x07 b=0x03 -> result=0x00; alu_less=1 only on the first SLTP cycle of the first case.
- WIDTH=8, AND 0xCA,0x0F -> 0x0A; OR 0xCA,0x0F -> 0xCF; back-to-back starts, with a start issued during busy ignored (exactly one done per accepted start).
- op=6 -> done 1 cycle after start, illegal=1, result=0, zero=1, alu_* stay 0.
- rst asserted on RUN cycle 4 of ADD -> next cycle IDLE, busy=0, result=0, no done; a new start then completes normally.

Source files
------------

// File: rtl/alu_serial_ctrl_if.sv
// Request/response bundle between the datapath and the bit-serial ALU sequencer.
// The datapath side is the master; the sequencer is the slave.
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport master (
        output start, op, src_a, src_b,
        input  busy, done, result, zero, illegal
    );

    modport slave (
        input  start, op, src_a, src_b,
        output busy, done, result, zero, illegal
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving one external 1-bit ALU slice, LSB first.
// SLT takes a second pass that feeds the captured sign bit into the slice's less input.
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    alu_serial_ctrl_if.slave    bus,
    output logic                alu_a,
    output logic                alu_b,
    output logic                alu_invert,
    output logic                alu_cin,
    output logic                alu_less,
    output logic [2:0]          alu_operation,
    input  logic                alu_dataOut,
    input  logic                alu_set,
    input  logic                alu_cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;

    typedef enum logic [1:0] {IDLE, RUN, SLTP, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [2:0]       op_reg, op_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             carry_reg, carry_next;
    logic             slt_reg, slt_next;
    logic             zero_reg, zero_next;
    logic             illegal_reg, illegal_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            result_reg  <= '0;
            op_reg      <= '0;
            cnt_reg     <= '0;
            carry_reg   <= 1'b0;
            slt_reg     <= 1'b0;
            zero_reg    <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            result_reg  <= result_next;
            op_reg      <= op_next;
            cnt_reg     <= cnt_next;
            carry_reg   <= carry_next;
            slt_reg     <= slt_next;
            zero_reg    <= zero_next;
            illegal_reg <= illegal_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        a_next        = a_reg;
        b_next        = b_reg;
        result_next   = result_reg;
        op_next       = op_reg;
        cnt_next      = cnt_reg;
        carry_next    = carry_reg;
        slt_next      = slt_reg;
        zero_next     = zero_reg;
        illegal_next  = illegal_reg;
        alu_a         = 1'b0;
        alu_b         = 1'b0;
        alu_invert    = 1'b0;
        alu_cin       = 1'b0;
        alu_less      = 1'b0;
        alu_operation = 3'b000;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    result_next = '0;
                    slt_next    = 1'b0;
                    cnt_next    = '0;
                    if (bus.op <= OP_SLT) begin
                        a_next       = bus.src_a;
                        b_next       = bus.src_b;
                        op_next      = bus.op;
                        carry_next   = (bus.op == OP_SUB) || (bus.op == OP_SLT);
                        zero_next    = 1'b0;
                        illegal_next = 1'b0;
                        state_next   = RUN;
                    end else begin
                        zero_next    = 1'b1;
                        illegal_next = 1'b1;
                        state_next   = DONE;
                    end
                end
            end
            RUN: begin
                alu_a      = a_reg[0];
                alu_b      = b_reg[0];
                alu_cin    = carry_reg;
                alu_invert = (op_reg == OP_SUB) || (op_reg == OP_SLT);
                case (op_reg)
                    OP_AND:  alu_operation = 3'b000;
                    OP_OR:   alu_operation = 3'b001;
                    default: alu_operation = 3'b010;
                endcase
                result_next = {alu_dataOut, result_reg[WIDTH-1:1]};
                carry_next  = alu_cout;
                a_next      = a_reg >> 1;
                b_next      = b_reg >> 1;
                cnt_next    = cnt_reg + CW'(1);
                if (cnt_reg == LAST) begin
                    // MSB sum bit is the sign of A-B; overflow deliberately not corrected
                    slt_next = alu_set;
                    cnt_next = '0;
                    if (op_reg == OP_SLT) begin
                        state_next = SLTP;
                    end else begin
                        zero_next  = (result_next == '0);
                        state_next = DONE;
                    end
                end
            end
            SLTP: begin
                alu_operation = 3'b011;
                alu_less      = slt_reg && (cnt_reg == '0);
                result_next   = {alu_dataOut, result_reg[WIDTH-1:1]};
                cnt_next      = cnt_reg + CW'(1);
                if (cnt_reg == LAST) begin
                    cnt_next   = '0;
                    zero_next  = (result_next == '0);
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_reg == RUN) || (state_reg == SLTP);
    assign bus.done    = (state_reg == DONE);
    assign bus.result  = result_reg;
    assign bus.zero    = zero_reg;
    assign bus.illegal = illegal_reg;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl at WIDTH=8 with a behavioural 1-bit ALU slice.
module tb_alu_serial_ctrl;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alu_a, alu_b, alu_invert, alu_cin, alu_less;
    logic [2:0] alu_operation;
    logic       alu_dataOut, alu_set, alu_cout;

    alu_serial_ctrl_if #(.WIDTH(W)) bus ();

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_invert    (alu_invert),
        .alu_cin       (alu_cin),
        .alu_less      (alu_less),
        .alu_operation (alu_operation),
        .alu_dataOut   (alu_dataOut),
        .alu_set       (alu_set),
        .alu_cout      (alu_cout)
    );

    always #5 clk = ~clk;

    // Behavioural model of the external slice: b optionally inverted, full adder, 4-way mux
    logic bb, sum;
    always_comb begin
        bb       = alu_b ^ alu_invert;
        sum      = alu_a ^ bb ^ alu_cin;
        alu_set  = sum;
        alu_cout = (alu_a & bb) | (alu_a & alu_cin) | (bb & alu_cin);
        case (alu_operation)
            3'b000:  alu_dataOut = alu_a & bb;
            3'b001:  alu_dataOut = alu_a | bb;
            3'b010:  alu_dataOut = sum;
            3'b011:  alu_dataOut = alu_less;
            default: alu_dataOut = 1'b0;
        endcase
    end

    int errors = 0;
    int checks = 0;

    int          lat, busy_cnt, extra_done;
    logic        done_seen, first_inv, first_cin, idle_alu;
    logic [31:0] less_mask;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic alu_any();
        return alu_a | alu_b | alu_invert | alu_cin | alu_less | (|alu_operation);
    endfunction

    // Issue one request and follow it to done; poke=1 also fires starts while busy and in DONE
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input bit poke);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        tick();
        bus.start = 1'b0;
        bus.src_a = ~a;
        bus.src_b = ~b;
        lat = 1; busy_cnt = 0; less_mask = '0; idle_alu = 1'b0;
        first_inv = alu_invert;
        first_cin = alu_cin;
        while (1) begin
            if (bus.busy) busy_cnt++;
            else if (alu_any()) idle_alu = 1'b1;
            if (alu_less && lat < 32) less_mask[lat] = 1'b1;
            if (poke && lat == 3) begin
                bus.start = 1'b1;
                bus.op    = 3'd1;
            end else if (poke && lat == 4) begin
                bus.start = 1'b0;
            end
            if (bus.done || lat >= 60) break;
            tick();
            lat++;
        end
        done_seen = bus.done;
        if (poke) bus.start = 1'b1;
        $display("op=%0d a=%02h b=%02h result=%02h zero=%0b illegal=%0b latency=%0d busy=%0d",
                 op, a, b, bus.result, bus.zero, bus.illegal, lat, busy_cnt);
        tick();
        bus.start = 1'b0;
        if (alu_any()) idle_alu = 1'b1;
        chk("done_pulse_width", {31'd0, bus.done}, 32'd0);
        extra_done = 0;
        if (poke) begin
            for (int i = 0; i < 12; i++) begin
                if (bus.done) extra_done++;
                tick();
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = '0;
        bus.src_a = '0;
        bus.src_b = '0;
        repeat (3) tick();

        chk("reset_busy",    {31'd0, bus.busy},    32'd0);
        chk("reset_done",    {31'd0, bus.done},    32'd0);
        chk("reset_result",  {24'd0, bus.result},  32'd0);
        chk("reset_zero",    {31'd0, bus.zero},    32'd0);
        chk("reset_illegal", {31'd0, bus.illegal}, 32'd0);
        chk("reset_alu",     {31'd0, alu_any()},   32'd0);
        rst = 1'b0;
        tick();

        // ADD with a busy-time start and a DONE-time start, both to be ignored
        run_op(3'd2, 8'hF0, 8'h1F, 1'b1);
        chk("add_done",     {31'd0, done_seen},  32'd1);
        chk("add_latency",  lat,                 32'd9);
        chk("add_busy",     busy_cnt,            32'd8);
        chk("add_result",   {24'd0, bus.result}, 32'h0F);
        chk("add_zero",     {31'd0, bus.zero},   32'd0);
        chk("add_ignored",  extra_done,          32'd0);
        chk("add_alu_idle", {31'd0, idle_alu},   32'd0);

        run_op(3'd3, 8'h05, 8'h05, 1'b0);
        chk("sub_result",   {24'd0, bus.result}, 32'h00);
        chk("sub_zero",     {31'd0, bus.zero},   32'd1);
        chk("sub_invert",   {31'd0, first_inv},  32'd1);
        chk("sub_cin",      {31'd0, first_cin},  32'd1);

        run_op(3'd4, 8'h03, 8'h07, 1'b0);
        chk("slt_lt_done",    {31'd0, done_seen},  32'd1);
        chk("slt_lt_latency", lat,                 32'd17);
        chk("slt_lt_busy",    busy_cnt,            32'd16);
        chk("slt_lt_result",  {24'd0, bus.result}, 32'h01);
        chk("slt_lt_less",    less_mask,           32'h200);

        run_op(3'd4, 8'h07, 8'h03, 1'b0);
        chk("slt_ge_result",  {24'd0, bus.result}, 32'h00);
        chk("slt_ge_zero",    {31'd0, bus.zero},   32'd1);
        chk("slt_ge_less",    less_mask,           32'h0);

        run_op(3'd0, 8'hCA, 8'h0F, 1'b0);
        chk("and_result",  {24'd0, bus.result}, 32'h0A);
        chk("and_latency", lat,                 32'd9);
        run_op(3'd1, 8'hCA, 8'h0F, 1'b0);
        chk("or_result",   {24'd0, bus.result}, 32'hCF);

        run_op(3'd6, 8'h12, 8'h34, 1'b0);
        chk("ill_done",    {31'd0, done_seen},   32'd1);
        chk("ill_latency", lat,                  32'd1);
        chk("ill_flag",    {31'd0, bus.illegal}, 32'd1);
        chk("ill_result",  {24'd0, bus.result},  32'h00);
        chk("ill_zero",    {31'd0, bus.zero},    32'd1);
        chk("ill_alu",     {31'd0, idle_alu},    32'd0);

        run_op(3'd2, 8'hFF, 8'h01, 1'b0);
        chk("add_wrap_result", {24'd0, bus.result},  32'h00);
        chk("add_wrap_zero",   {31'd0, bus.zero},    32'd1);
        chk("illegal_cleared", {31'd0, bus.illegal}, 32'd0);

        run_op(3'd1, 8'hCA, 8'h0F, 1'b0);
        // Reset on RUN cycle 4 of an ADD
        bus.start = 1'b1;
        bus.op    = 3'd2;
        bus.src_a = 8'h11;
        bus.src_b = 8'h22;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        chk("rst_mid_busy_before", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy",   {31'd0, bus.busy},   32'd0);
        chk("rst_mid_result", {24'd0, bus.result}, 32'h00);
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) extra_done++;
            tick();
        end
        chk("rst_mid_no_done", extra_done, 32'd0);

        run_op(3'd2, 8'h7F, 8'h01, 1'b0);
        chk("post_rst_done",   {31'd0, done_seen},  32'd1);
        chk("post_rst_result", {24'd0, bus.result}, 32'h80);
        chk("post_rst_zero",   {31'd0, bus.zero},   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
